// File: rtl/nor_fanout_tester_if.sv
// Control/status bundle between a fanout-test top and the NOR chain tester.
// The master side launches runs; the slave side (the tester) reports results.
interface nor_fanout_tester_if #(
    parameter int FANOUT = 4,
    parameter int CNT_W  = 16
);
    logic              start;
    logic [CNT_W-1:0]  num_trans;
    logic [FANOUT-1:0] inj_fault;
    logic              busy;
    logic              done;
    logic              drive;
    logic [FANOUT-1:0] branch_out;
    logic [CNT_W-1:0]  trans_cnt;
    logic [CNT_W-1:0]  err_cnt;
    logic [FANOUT-1:0] mismatch_mask;

    modport master (
        output start, num_trans, inj_fault,
        input  busy, done, drive, branch_out, trans_cnt, err_cnt, mismatch_mask
    );

    modport slave (
        input  start, num_trans, inj_fault,
        output busy, done, drive, branch_out, trans_cnt, err_cnt, mismatch_mask
    );
endinterface

// File: rtl/nor_fanout_tester.sv
// Self-test wrapper around a NOR2_X1 trunk/fanout chain. A small FSM toggles the
// trunk input, waits a settle time, then compares every branch output against the
// value implied by the chain's inversion parity and accumulates mismatches.
module nor_fanout_tester #(
    parameter int TRUNK_LEN     = 6,
    parameter int FANOUT        = 4,
    parameter int BRANCH_LEN    = 4,
    parameter int SETTLE_CYCLES = 8,
    parameter int CNT_W         = 16
) (
    input logic               clk,
    input logic               rst,
    nor_fanout_tester_if.slave bus
);

    // An odd total number of inverting stages flips the launched value.
    localparam logic POL   = 1'((TRUNK_LEN + BRANCH_LEN) % 2);
    localparam int   SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    // Wide enough to hold a full counter plus one sample's worth of mismatches.
    localparam int   SUM_W = CNT_W + $clog2(FANOUT + 1);
    localparam logic [SUM_W-1:0] ERR_MAX = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              drive_q;
    logic [SET_W-1:0]  settle_cnt;
    logic [CNT_W-1:0]  num_cap;
    logic [CNT_W-1:0]  trans_cnt_q;
    logic [CNT_W-1:0]  err_cnt_q;
    logic [FANOUT-1:0] mask_q;
    logic [FANOUT-1:0] branch_raw;
    logic              fanout_node;
    logic              exp_bit;
    logic [FANOUT-1:0] sample_mm;
    logic [SUM_W-1:0]  mm_pop;
    logic [SUM_W-1:0]  err_sum;
    logic [CNT_W-1:0]  err_next;
    logic [CNT_W-1:0]  trans_next;
    logic              busy_c;
    logic              done_c;

    function automatic logic [SUM_W-1:0] popcount(input logic [FANOUT-1:0] v);
        logic [SUM_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < FANOUT; i++) begin
            acc = acc + SUM_W'(v[i]);
        end
        return acc;
    endfunction

    // ------------------------------------------------------------------
    // Chain: every stage is a discrete NOR2_X1 with A2 grounded, acting as
    // an inverter. Each stage owns its own nets so nothing can be merged.
    // ------------------------------------------------------------------
    for (genvar t = 0; t < TRUNK_LEN; t++) begin : g_trunk
        (* keep = "true", dont_touch = "true" *) logic stage_in;
        (* keep = "true", dont_touch = "true" *) logic stage_out;
        if (t == 0) begin : g_head
            assign stage_in = drive_q;
        end else begin : g_body
            assign stage_in = g_trunk[t-1].stage_out;
        end
        (* keep = "true", dont_touch = "true" *)
        NOR2_X1 u_nor (.A1(stage_in), .A2(1'b0), .ZN(stage_out));
    end

    assign fanout_node = g_trunk[TRUNK_LEN-1].stage_out;

    for (genvar b = 0; b < FANOUT; b++) begin : g_branch
        for (genvar s = 0; s < BRANCH_LEN; s++) begin : g_stage
            (* keep = "true", dont_touch = "true" *) logic stage_in;
            (* keep = "true", dont_touch = "true" *) logic stage_out;
            if (s == 0) begin : g_head
                assign stage_in = fanout_node;
            end else begin : g_body
                assign stage_in = g_stage[s-1].stage_out;
            end
            (* keep = "true", dont_touch = "true" *)
            NOR2_X1 u_nor (.A1(stage_in), .A2(1'b0), .ZN(stage_out));
        end
        assign branch_raw[b] = g_stage[BRANCH_LEN-1].stage_out;
    end

    // Sample-time comparison and saturating error accumulation.
    always_comb begin
        exp_bit    = drive_q ^ POL;
        sample_mm  = (branch_raw ^ bus.inj_fault) ^ {FANOUT{exp_bit}};
        mm_pop     = popcount(sample_mm);
        err_sum    = {{(SUM_W-CNT_W){1'b0}}, err_cnt_q} + mm_pop;
        err_next   = (err_sum > ERR_MAX) ? {CNT_W{1'b1}} : err_sum[CNT_W-1:0];
        trans_next = trans_cnt_q + 1'b1;
    end

    // State register; reset aborts any run without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: launch, settle for SETTLE_CYCLES, sample, repeat N times.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_next = (bus.num_trans == '0) ? S_DONE : S_LAUNCH;
                end
            end
            S_LAUNCH: state_next = S_SETTLE;
            S_SETTLE: begin
                if (settle_cnt == '0) begin
                    state_next = S_SAMPLE;
                end
            end
            S_SAMPLE: state_next = (trans_next == num_cap) ? S_DONE : S_LAUNCH;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Moore status outputs decoded from the current state.
    always_comb begin
        busy_c = 1'b0;
        done_c = 1'b0;
        unique case (state)
            S_LAUNCH, S_SETTLE, S_SAMPLE: busy_c = 1'b1;
            S_DONE:                       done_c = 1'b1;
            default: begin
                busy_c = 1'b0;
                done_c = 1'b0;
            end
        endcase
    end

    // Datapath: run capture, drive toggling, settle timer and result counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            drive_q     <= 1'b0;
            settle_cnt  <= '0;
            num_cap     <= '0;
            trans_cnt_q <= '0;
            err_cnt_q   <= '0;
            mask_q      <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        num_cap     <= bus.num_trans;
                        trans_cnt_q <= '0;
                        err_cnt_q   <= '0;
                        mask_q      <= '0;
                    end
                end
                S_LAUNCH: begin
                    drive_q    <= ~drive_q;
                    settle_cnt <= SET_W'(SETTLE_CYCLES - 1);
                end
                S_SETTLE: begin
                    if (settle_cnt != '0) begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                S_SAMPLE: begin
                    err_cnt_q   <= err_next;
                    mask_q      <= mask_q | sample_mm;
                    trans_cnt_q <= trans_next;
                end
                default: begin
                    settle_cnt <= settle_cnt;
                end
            endcase
        end
    end

    assign bus.busy          = busy_c;
    assign bus.done          = done_c;
    assign bus.drive         = drive_q;
    assign bus.branch_out    = branch_raw;
    assign bus.trans_cnt     = trans_cnt_q;
    assign bus.err_cnt       = err_cnt_q;
    assign bus.mismatch_mask = mask_q;

endmodule

// Behavioural stand-in for the library NOR2_X1 cell used by the chain.
module NOR2_X1 (
    input  logic A1,
    input  logic A2,
    output logic ZN
);
    assign ZN = ~(A1 | A2);
endmodule

// File: tb/tb_nor_fanout_tester.sv
// Scoreboard bench for nor_fanout_tester: runs are queued with hand-computed
// results, and per-DUT monitors compare them whenever done pulses.
module tb_nor_fanout_tester;

    logic clk = 1'b0;
    logic rst;

    nor_fanout_tester_if #(.FANOUT(4), .CNT_W(16)) bus0 ();
    nor_fanout_tester_if #(.FANOUT(4), .CNT_W(4))  bus1 ();

    nor_fanout_tester #(
        .TRUNK_LEN(6), .FANOUT(4), .BRANCH_LEN(4), .SETTLE_CYCLES(8), .CNT_W(16)
    ) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );

    nor_fanout_tester #(
        .TRUNK_LEN(6), .FANOUT(4), .BRANCH_LEN(4), .SETTLE_CYCLES(8), .CNT_W(4)
    ) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    typedef struct {
        int          done_cyc;
        logic [15:0] trans;
        logic [15:0] err;
        logic [3:0]  mask;
        logic        drive;
        logic [3:0]  br;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t m0;
    exp_t m1;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    // 10 ns clock.
    always #5 clk = ~clk;

    // Free-running cycle count used to time done pulses.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor for the CNT_W=16 instance.
    always @(negedge clk) begin
        if (bus0.done === 1'b1) begin
            if (q0.size() == 0) begin
                checkOutput("dut0 unexpected done", 32'(bus0.done), 32'd0);
            end else begin
                m0 = q0.pop_front();
                checkOutput("dut0 done cycle", 32'(cyc), 32'(m0.done_cyc));
                checkOutput("dut0 trans_cnt", 32'(bus0.trans_cnt), 32'(m0.trans));
                checkOutput("dut0 err_cnt", 32'(bus0.err_cnt), 32'(m0.err));
                checkOutput("dut0 mismatch_mask", 32'(bus0.mismatch_mask), 32'(m0.mask));
                checkOutput("dut0 drive", 32'(bus0.drive), 32'(m0.drive));
                checkOutput("dut0 branch_out", 32'(bus0.branch_out), 32'(m0.br));
                checkOutput("dut0 busy at done", 32'(bus0.busy), 32'd0);
            end
        end
    end

    // Scoreboard monitor for the CNT_W=4 saturation instance.
    always @(negedge clk) begin
        if (bus1.done === 1'b1) begin
            if (q1.size() == 0) begin
                checkOutput("dut1 unexpected done", 32'(bus1.done), 32'd0);
            end else begin
                m1 = q1.pop_front();
                checkOutput("dut1 done cycle", 32'(cyc), 32'(m1.done_cyc));
                checkOutput("dut1 trans_cnt", 32'(bus1.trans_cnt), 32'(m1.trans));
                checkOutput("dut1 err_cnt", 32'(bus1.err_cnt), 32'(m1.err));
                checkOutput("dut1 mismatch_mask", 32'(bus1.mismatch_mask), 32'(m1.mask));
                checkOutput("dut1 drive", 32'(bus1.drive), 32'(m1.drive));
                checkOutput("dut1 branch_out", 32'(bus1.branch_out), 32'(m1.br));
            end
        end
    end

    // Issue a start at a negedge, queue the expected result, check busy next cycle.
    task automatic applyStimulus(input int sel, input int n, input logic [3:0] inj,
                                 input bit expect_done, input int lat,
                                 input int e_trans, input int e_err, input logic [3:0] e_mask,
                                 input logic e_drive, input logic [3:0] e_br);
        exp_t e;
        @(negedge clk);
        e.done_cyc = cyc + lat;
        e.trans    = 16'(e_trans);
        e.err      = 16'(e_err);
        e.mask     = e_mask;
        e.drive    = e_drive;
        e.br       = e_br;
        if (sel == 0) begin
            bus0.start     = 1'b1;
            bus0.num_trans = 16'(n);
            bus0.inj_fault = inj;
            if (expect_done) q0.push_back(e);
        end else begin
            bus1.start     = 1'b1;
            bus1.num_trans = 4'(n);
            bus1.inj_fault = inj;
            if (expect_done) q1.push_back(e);
        end
        @(negedge clk);
        if (sel == 0) begin
            bus0.start = 1'b0;
            checkOutput("dut0 busy after start", 32'(bus0.busy), (n != 0) ? 32'd1 : 32'd0);
        end else begin
            bus1.start = 1'b0;
            checkOutput("dut1 busy after start", 32'(bus1.busy), (n != 0) ? 32'd1 : 32'd0);
        end
    endtask

    // Wait (bounded) until the monitor has consumed every queued result.
    task automatic waitDone(input int sel, input int budget);
        bit finished;
        finished = 1'b0;
        for (int i = 0; i < budget && !finished; i++) begin
            @(negedge clk);
            #1;
            if (sel == 0) finished = (q0.size() == 0);
            else          finished = (q1.size() == 0);
        end
        if (!finished) begin
            if (sel == 0) begin
                checkOutput("dut0 done timeout", 32'(q0.size()), 32'd0);
                q0.delete();
            end else begin
                checkOutput("dut1 done timeout", 32'(q1.size()), 32'd0);
                q1.delete();
            end
        end
    endtask

    // Hard stop in case something stalls outside the bounded waits.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst            = 1'b1;
        bus0.start     = 1'b0;
        bus0.num_trans = '0;
        bus0.inj_fault = '0;
        bus1.start     = 1'b0;
        bus1.num_trans = '0;
        bus1.inj_fault = '0;

        // Reset for two cycles: everything zero, branch_out follows drive=0 (even parity).
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset busy", 32'(bus0.busy), 32'd0);
        checkOutput("reset done", 32'(bus0.done), 32'd0);
        checkOutput("reset drive", 32'(bus0.drive), 32'd0);
        checkOutput("reset trans_cnt", 32'(bus0.trans_cnt), 32'd0);
        checkOutput("reset err_cnt", 32'(bus0.err_cnt), 32'd0);
        checkOutput("reset mismatch_mask", 32'(bus0.mismatch_mask), 32'd0);
        checkOutput("reset branch_out", 32'(bus0.branch_out), 32'h0);
        checkOutput("reset dut1 drive", 32'(bus1.drive), 32'd0);
        rst = 1'b0;

        // Run A: 5 clean transitions, done at cycle 1+5*10=51, drive ends at 1.
        applyStimulus(0, 5, 4'b0000, 1'b1, 51, 5, 0, 4'b0000, 1'b1, 4'b1111);
        waitDone(0, 60);

        // Aborted run: reset at cycle 20 (drive=1, one sample of 2 mismatches taken).
        applyStimulus(0, 5, 4'b0011, 1'b0, 0, 0, 0, 4'b0000, 1'b0, 4'b0000);
        repeat (19) @(negedge clk);
        checkOutput("pre-reset trans_cnt", 32'(bus0.trans_cnt), 32'd1);
        checkOutput("pre-reset err_cnt", 32'(bus0.err_cnt), 32'd2);
        checkOutput("pre-reset drive", 32'(bus0.drive), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid-run reset busy", 32'(bus0.busy), 32'd0);
        checkOutput("mid-run reset drive", 32'(bus0.drive), 32'd0);
        checkOutput("mid-run reset trans_cnt", 32'(bus0.trans_cnt), 32'd0);
        checkOutput("mid-run reset err_cnt", 32'(bus0.err_cnt), 32'd0);
        checkOutput("mid-run reset mismatch_mask", 32'(bus0.mismatch_mask), 32'd0);
        checkOutput("mid-run reset branch_out", 32'(bus0.branch_out), 32'h0);
        rst = 1'b0;
        repeat (60) @(negedge clk);

        // Run B: fault on branches 0 and 2, 3 samples x 2 = 6 errors; drive 0 -> 1.
        applyStimulus(0, 3, 4'b0101, 1'b1, 31, 3, 6, 4'b0101, 1'b1, 4'b1111);
        waitDone(0, 40);

        // Run C: zero transitions, done the cycle after start, counters cleared.
        applyStimulus(0, 0, 4'b0000, 1'b1, 1, 0, 0, 4'b0000, 1'b1, 4'b1111);
        waitDone(0, 10);
        checkOutput("zero-run busy after done", 32'(bus0.busy), 32'd0);

        // Run D: 2 transitions with branch 3 faulted; mid-run start and num_trans change ignored.
        applyStimulus(0, 2, 4'b1000, 1'b1, 21, 2, 2, 4'b1000, 1'b1, 4'b1111);
        repeat (4) @(negedge clk);
        bus0.start     = 1'b1;
        bus0.num_trans = 16'd7;
        @(negedge clk);
        bus0.start = 1'b0;
        waitDone(0, 30);
        repeat (2) @(negedge clk);
        checkOutput("hold trans_cnt after done", 32'(bus0.trans_cnt), 32'd2);
        checkOutput("hold mismatch_mask after done", 32'(bus0.mismatch_mask), 32'h8);

        // Run E: single clean transition, drive 1 -> 0, previous errors cleared.
        applyStimulus(0, 1, 4'b0000, 1'b1, 11, 1, 0, 4'b0000, 1'b0, 4'b0000);
        waitDone(0, 20);

        // CNT_W=4: 5 samples x 4 errors saturate at 15; mid-run start pulse ignored.
        applyStimulus(1, 5, 4'b1111, 1'b1, 51, 5, 15, 4'b1111, 1'b1, 4'b1111);
        repeat (8) @(negedge clk);
        bus1.start     = 1'b1;
        bus1.num_trans = 4'd2;
        @(negedge clk);
        bus1.start = 1'b0;
        waitDone(1, 60);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
